// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op codes, FSM states and op classification for alu_seq
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0110,
    OP_PASSB = 4'b0111,
    OP_MUL   = 4'b1000,
    OP_UDIV  = 4'b1001,
    OP_UREM  = 4'b1010,
    OP_NOR   = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_e;

  function automatic logic op_is_iter(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_UDIV) || (op == OP_UREM);
  endfunction

endpackage

// File: rtl/alu_comb_n.sv
// rtl/alu_comb_n.sv - single-cycle logic/arith ops with carry and signed overflow
module alu_comb_n
  import alu_seq_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   op,
  output logic [N-1:0] result,
  output logic         carry,
  output logic         overflow
);

  logic [N-1:0] b_eff;
  logic [N:0]   sum;

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    // SUB is a + ~b + 1, so carry means "no borrow"
    b_eff    = (op == OP_SUB) ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, (op == OP_SUB)};
    case (op)
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_PASSB: result = b;
      OP_NOR:   result = ~(a | b);
      OP_ADD, OP_SUB: begin
        result   = sum[N-1:0];
        carry    = sum[N];
        overflow = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU: single-cycle ops, shift-add MUL, restoring UDIV/UREM
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int N  = 64,
  parameter int CW = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUControl,
  output logic         ready,
  output logic         busy,
  output logic         valid,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         negative,
  output logic         carry,
  output logic         overflow,
  output logic         divzero
);

  state_e        state, state_nx;
  logic [3:0]    op_q;
  logic [N-1:0]  acc;
  logic [N-1:0]  xr;
  logic [N-1:0]  yr;
  logic [CW-1:0] cnt;
  logic [N-1:0]  result_q;
  logic          carry_q, overflow_q, divzero_q;

  logic [N-1:0]  comb_result;
  logic          comb_carry, comb_overflow;

  logic          accept, last;
  logic [N-1:0]  mul_acc_nx, rem_nx, quo_nx, diff;
  logic [N:0]    trial;
  logic          ge;

  alu_comb_n #(.N(N)) u_comb (
    .a        (a),
    .b        (b),
    .op       (ALUControl),
    .result   (comb_result),
    .carry    (comb_carry),
    .overflow (comb_overflow)
  );

  assign accept = (state == IDLE) && start;
  assign last   = (state == ITER) && (cnt == CW'(N - 1));

  // MUL: acc += xr when yr[0]; xr shifts left, yr right.
  // DIV: acc is the remainder, xr shifts dividend bits out and quotient bits in, yr is the divisor.
  always_comb begin
    mul_acc_nx = yr[0] ? acc + xr : acc;
    trial      = {acc, xr[N-1]};
    ge         = trial >= {1'b0, yr};
    diff       = trial[N-1:0] - yr;
    rem_nx     = ge ? diff : trial[N-1:0];
    quo_nx     = {xr[N-2:0], ge};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = op_is_iter(ALUControl) ? ITER : DONE;
      ITER:    if (cnt == CW'(N - 1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= '0;
      acc        <= '0;
      xr         <= '0;
      yr         <= '0;
      cnt        <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      divzero_q  <= 1'b0;
    end else if (accept) begin
      op_q <= ALUControl;
      acc  <= '0;
      xr   <= a;
      yr   <= b;
      cnt  <= '0;
      if (!op_is_iter(ALUControl)) begin
        result_q   <= comb_result;
        carry_q    <= comb_carry;
        overflow_q <= comb_overflow;
        divzero_q  <= 1'b0;
      end
    end else if (state == ITER) begin
      cnt <= cnt + 1'b1;
      if (op_q == OP_MUL) begin
        acc <= mul_acc_nx;
        xr  <= xr << 1;
        yr  <= yr >> 1;
      end else begin
        acc <= rem_nx;
        xr  <= quo_nx;
      end
      if (last) begin
        case (op_q)
          OP_MUL:  result_q <= mul_acc_nx;
          OP_UDIV: result_q <= quo_nx;
          default: result_q <= rem_nx;
        endcase
        carry_q    <= 1'b0;
        overflow_q <= 1'b0;
        // yr only shifts for MUL, so for divides it still holds the divisor here
        divzero_q  <= (op_q != OP_MUL) && (yr == '0);
      end
    end
  end

  assign ready    = (state == IDLE);
  assign busy     = (state == ITER);
  assign valid    = (state == DONE);
  assign result   = result_q;
  assign zero     = (result_q == '0);
  assign negative = result_q[N-1];
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign divzero  = divzero_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - table and scoreboard bench for alu_seq at N=64 and N=8
module tb_alu_seq;

  typedef struct {
    logic [63:0] res;
    logic [3:0]  nzcv;
    logic        dz;
    int          lat;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst64, start64, ready64, busy64, valid64, z64, n64, c64, v64, dz64;
  logic [63:0] a64, b64, res64;
  logic [3:0]  op64;
  logic        rst8, start8, ready8, busy8, valid8, z8, n8, c8, v8, dz8;
  logic [7:0]  a8, b8, res8;
  logic [3:0]  op8;

  alu_seq #(.N(64)) d64 (
    .clk(clk), .reset(rst64), .start(start64), .a(a64), .b(b64), .ALUControl(op64),
    .ready(ready64), .busy(busy64), .valid(valid64), .result(res64), .zero(z64),
    .negative(n64), .carry(c64), .overflow(v64), .divzero(dz64)
  );

  alu_seq #(.N(8)) d8 (
    .clk(clk), .reset(rst8), .start(start8), .a(a8), .b(b8), .ALUControl(op8),
    .ready(ready8), .busy(busy8), .valid(valid8), .result(res8), .zero(z8),
    .negative(n8), .carry(c8), .overflow(v8), .divzero(dz8)
  );

  int checks = 0;
  int failures = 0;
  int pulses64 = 0;
  int pulses8 = 0;
  exp_t q64[$];
  exp_t q8[$];

  always @(posedge clk) begin
    if (valid64) pulses64 <= pulses64 + 1;
    if (valid8)  pulses8  <= pulses8 + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [3:0] op,
                                 input logic [63:0] a_in, input logic [63:0] b_in);
    exp_t e;
    logic [64:0] s;
    logic [63:0] mask, a, b, r;
    logic c, v;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    a = a_in & mask;
    b = b_in & mask;
    c = 1'b0; v = 1'b0; r = '0; s = '0;
    e.dz = 1'b0;
    e.lat = 1;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[63:0] & mask; c = s[w];
        v = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
      end
      4'b0110: begin
        s = {1'b0, a} + {1'b0, (~b & mask)} + 65'd1;
        r = s[63:0] & mask; c = s[w];
        v = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
      end
      4'b0111: r = b;
      4'b1100: r = ~(a | b) & mask;
      4'b1000: begin r = (a * b) & mask; e.lat = w + 1; end
      4'b1001: begin r = (b == 0) ? mask : a / b; e.dz = (b == 0); e.lat = w + 1; end
      4'b1010: begin r = (b == 0) ? a : a % b; e.dz = (b == 0); e.lat = w + 1; end
      default: r = '0;
    endcase
    e.res = r;
    e.nzcv = {r[w-1], (r == 0), c, v};
    return e;
  endfunction

  function automatic vec_t mk(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] res, input logic [3:0] nzcv, input logic dz,
                              input int lat);
    vec_t t;
    t.op = op; t.a = a; t.b = b;
    t.e.res = res; t.e.nzcv = nzcv; t.e.dz = dz; t.e.lat = lat;
    return t;
  endfunction

  task automatic do64(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                      input exp_t e, input string tag);
    int t, lat, busyc;
    exp_t x;
    t = 0;
    while (!ready64 && t < 200) begin @(negedge clk); t++; end
    chk({tag, " ready_before"}, 64'(ready64), 64'd1);
    start64 = 1'b1; op64 = op; a64 = a; b64 = b;
    q64.push_back(e);
    @(posedge clk); lat = 1; @(negedge clk);
    start64 = 1'b0; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; op64 = 4'($urandom);
    busyc = 0;
    while (!valid64 && lat < 300) begin
      if (busy64) busyc++;
      @(posedge clk); lat++; @(negedge clk);
    end
    x = q64.pop_front();
    chk({tag, " valid_seen"}, 64'(valid64), 64'd1);
    chk({tag, " latency"}, 64'(lat), 64'(x.lat));
    chk({tag, " result"}, res64, x.res);
    chk({tag, " nzcv"}, 64'({n64, z64, c64, v64}), 64'(x.nzcv));
    chk({tag, " divzero"}, 64'(dz64), 64'(x.dz));
    chk({tag, " busy_cycles"}, 64'(busyc), 64'(x.lat - 1));
    chk({tag, " ready_in_done"}, 64'(ready64), 64'd0);
    @(negedge clk);
    chk({tag, " after_done"}, 64'({ready64, valid64}), 64'b10);
  endtask

  task automatic do8(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                     input exp_t e, input logic inject, input string tag);
    int t, lat, busyc;
    exp_t x;
    t = 0;
    while (!ready8 && t < 200) begin @(negedge clk); t++; end
    chk({tag, " ready_before"}, 64'(ready8), 64'd1);
    start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    q8.push_back(e);
    @(posedge clk); lat = 1; @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 4'($urandom);
    busyc = 0;
    while (!valid8 && lat < 300) begin
      if (busy8) busyc++;
      start8 = inject && (lat == 3);
      if (start8) op8 = 4'b0010;
      @(posedge clk); lat++; @(negedge clk);
    end
    start8 = 1'b0;
    x = q8.pop_front();
    chk({tag, " valid_seen"}, 64'(valid8), 64'd1);
    chk({tag, " latency"}, 64'(lat), 64'(x.lat));
    chk({tag, " result"}, 64'(res8), x.res);
    chk({tag, " nzcv"}, 64'({n8, z8, c8, v8}), 64'(x.nzcv));
    chk({tag, " divzero"}, 64'(dz8), 64'(x.dz));
    chk({tag, " busy_cycles"}, 64'(busyc), 64'(x.lat - 1));
    chk({tag, " ready_in_done"}, 64'(ready8), 64'd0);
    @(negedge clk);
    chk({tag, " after_done"}, 64'({ready8, valid8}), 64'b10);
  endtask

  vec_t tbl[12];
  logic [3:0] codes64[7];
  int p;

  initial begin
    rst64 = 1'b1; start64 = 1'b0; a64 = '0; b64 = '0; op64 = '0;
    rst8  = 1'b1; start8  = 1'b0; a8  = '0; b8  = '0; op8  = '0;
    repeat (2) @(negedge clk);
    chk("reset64 ctrl_flags", 64'({ready64, busy64, valid64, z64, n64, c64, v64, dz64}), 64'b1001_0000);
    chk("reset64 result", res64, 64'd0);
    chk("reset8 ctrl_flags", 64'({ready8, busy8, valid8, z8, n8, c8, v8, dz8}), 64'b1001_0000);
    chk("reset8 result", 64'(res8), 64'd0);
    rst64 = 1'b0; rst8 = 1'b0;
    @(negedge clk);

    // Reset in the middle of a MUL aborts it silently
    start64 = 1'b1; op64 = 4'b1000; a64 = 64'd5; b64 = 64'd7;
    @(posedge clk); @(negedge clk);
    start64 = 1'b0;
    p = pulses64;
    repeat (9) @(negedge clk);
    chk("midmul busy_before_reset", 64'(busy64), 64'd1);
    rst64 = 1'b1; #1;
    chk("midmul reset ctrl", 64'({ready64, busy64, valid64}), 64'b100);
    chk("midmul reset result_zero", {res64[62:0], z64}, 64'd1);
    @(negedge clk); rst64 = 1'b0;
    repeat (80) @(negedge clk);
    chk("midmul no_valid", 64'(pulses64 - p), 64'd0);
    chk("midmul idle_after", 64'({ready64, z64}), 64'b11);

    tbl[0]  = mk(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0110, 1'b0, 1);
    tbl[1]  = mk(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1001, 1'b0, 1);
    tbl[2]  = mk(4'b0110, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0, 1);
    tbl[3]  = mk(4'b1100, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0, 1);
    tbl[4]  = mk(4'b1111, 64'd9, 64'd3, 64'd0, 4'b0100, 1'b0, 1);
    tbl[5]  = mk(4'b0000, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0F00_0F00_0F00_0F00, 4'b0000, 1'b0, 1);
    tbl[6]  = mk(4'b0001, 64'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 4'b1000, 1'b0, 1);
    tbl[7]  = mk(4'b0111, 64'd1234, 64'd5, 64'd5, 4'b0000, 1'b0, 1);
    tbl[8]  = mk(4'b0110, 64'd5, 64'd5, 64'd0, 4'b0110, 1'b0, 1);
    tbl[9]  = mk(4'b0110, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1'b0, 1);
    tbl[10] = mk(4'b1000, 64'd5, 64'd7, 64'd35, 4'b0000, 1'b0, 65);
    tbl[11] = mk(4'b1001, 64'd100, 64'd7, 64'd14, 4'b0000, 1'b0, 65);
    for (int i = 0; i < 12; i++) do64(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e, $sformatf("tbl64[%0d]", i));

    codes64 = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011};
    for (int i = 0; i < 16; i++) begin
      logic [3:0] op;
      logic [63:0] ra, rb;
      op = codes64[$urandom_range(0, 6)];
      ra = {$urandom, $urandom};
      rb = (i % 4 == 0) ? ra : {$urandom, $urandom};
      do64(op, ra, rb, model(64, op, ra, rb), $sformatf("rnd64[%0d]", i));
    end

    // MUL with a stray start during ITER: exactly one result, no extra accept
    p = pulses8;
    do8(4'b1000, 64'd25, 64'd12, '{64'h2C, 4'b0000, 1'b0, 9}, 1'b1, "mul8 25x12");
    repeat (5) @(negedge clk);
    chk("mul8 single_pulse", 64'(pulses8 - p), 64'd1);
    chk("mul8 no_extra_accept", 64'(ready8), 64'd1);

    do8(4'b1001, 64'd200, 64'd7, '{64'd28, 4'b0000, 1'b0, 9}, 1'b0, "udiv8 200/7");
    do8(4'b1010, 64'd200, 64'd7, '{64'd4, 4'b0000, 1'b0, 9}, 1'b0, "urem8 200%7");
    do8(4'b1001, 64'd9, 64'd0, '{64'hFF, 4'b1000, 1'b1, 9}, 1'b0, "udiv8 9/0");
    do8(4'b1010, 64'd9, 64'd0, '{64'd9, 4'b0000, 1'b1, 9}, 1'b0, "urem8 9%0");
    for (int i = 0; i < 20; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); op8 = 4'($urandom);
      @(negedge clk);
      chk($sformatf("hold8[%0d]", i), 64'({res8, dz8, valid8}), 64'({8'd9, 1'b1, 1'b0}));
    end

    for (int i = 0; i < 24; i++) begin
      logic [3:0] op;
      logic [63:0] ra, rb;
      op = 4'($urandom);
      ra = 64'($urandom_range(0, 255));
      rb = (i % 6 == 0) ? 64'd0 : 64'($urandom_range(0, 255));
      do8(op, ra, rb, model(8, op, ra, rb), 1'b0, $sformatf("rnd8[%0d]", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the datapath ALU.
- Keeps the six single-cycle operations and their encodings, and adds full NZCV flags.
- Adds iterative unsigned multiply (shift-add) and unsigned divide/remainder (restoring).
- Sits in the execute stage behind a start/ready/valid handshake, so the control FSM can stall on long operations.

Parameters:
N, 64, operand/result width (>=4)
CW, $clog2(N+1), iteration counter width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  request; accepted only when ready=1
a  in  N  operand A, sampled on acceptance edge
b  in  N  operand B, sampled on acceptance edge
ALUControl  in  4  operation code, sampled on acceptance edge
ready  out  1  block idle, can accept start
busy  out  1  iterative op in progress
valid  out  1  one-cycle pulse: result/flags are new this cycle
result  out  N  last completed result, held until next completion
zero  out  1  result == 0
negative  out  1  result[N-1]
carry  out  1  carry-out (ADD) / no-borrow (SUB), else 0
overflow  out  1  signed overflow (ADD/SUB), else 0
divzero  out  1  set with valid when UDIV/UREM had b == 0

Behaviour:
- Reset (async): state IDLE, result=0, zero=1, all other outputs 0 except ready=1, counter=0.
- Reset asserted mid-operation aborts the operation with no valid pulse.
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (a-b), 0111 PASSB, 1100 NOR.
  - 1000 MUL: low N bits of a*b, unsigned.
  - 1001 UDIV: a/b. 1010 UREM: a%b.
  - Any other code: result 0, L=1.
- FSM states: IDLE, ITER, DONE.
  - IDLE: ready=1. On start, operands are latched and the state moves as follows:
    - Single-cycle op: result and flags computed from inputs and registered on the same edge; next state DONE.
    - MUL/UDIV/UREM: load accumulator/remainder=0, counter=0; next state ITER.
  - ITER: busy=1, ready=0. One bit per edge; counter increments. On the edge where the counter reaches N-1, the final result and flags are registered and the state moves to DONE.
  - DONE: valid=1 for exactly one cycle, ready=0; next state IDLE.
- Latency L is counted from the acceptance edge to the cycle in which valid is high:
  - single-cycle ops: valid high in the cycle after the acceptance edge (L=1).
  - MUL/UDIV/UREM: N+1.
- Back-to-back: start is ignored in ITER and DONE; a new op is accepted no earlier than the first IDLE cycle after valid.
- ADD/SUB use an N+1-bit sum.
  - carry = bit N of that sum. SUB computes a + ~b + 1.
  - overflow = (a[N-1]==b'[N-1]) && (sum[N-1]!=a[N-1]), where b' = b for ADD, ~b for SUB.
- MUL: product truncated to N bits. carry=overflow=0; no high-half output.
- Divide by zero:
  - UDIV: result all-ones.
  - UREM: result = a.
  - divzero=1 and L is unchanged (still N+1, no early exit).
- divzero is 0 for all other ops.
- zero/negative are always derived from the registered result and update only together with it.
- result and all flags hold between completions; operand input changes outside acceptance have no effect.

Decomposition:
- Package alu_seq_pkg:
  - enum alu_op_e for the 4-bit codes above.
  - enum state_e {IDLE, ITER, DONE}.
  - localparam OP_IS_ITER function (MUL/UDIV/UREM).
- Sub-module alu_comb_n, parametrised by N: purely combinational single-cycle ops plus NZCV generation, instantiated once.
- alu_seq owns the FSM, counter, shift registers and output registers.

Test Plan:
1. N=64, reset mid-MUL: start MUL a=5,b=7, assert reset at cycle 10 -> ready=1 and result=0, zero=1; no valid pulse.
2. N=64 ADD a=64'hFFFF_FFFF_FFFF_FFFF, b=1 -> valid at L=1; result=0, zero=1, carry=1, overflow=0. Then ADD a=64'h7FFF_FFFF_FFFF_FFFF, b=1 -> result=64'h8000_0000_0000_0000, negative=1, overflow=1, carry=0.
3. N=64 SUB a=3, b=5 -> result=64'hFFFF_FFFF_FFFF_FFFE, negative=1, carry=0. Then NOR a=0, b=0 -> result=all-ones, carry=0. Unknown code 4'b1111 -> result=0, zero=1.
4. N=8 MUL a=8'd25, b=8'd12 -> valid exactly 9 cycles after acceptance; result=8'h2C (300 mod 256), busy high 8 cycles. start pulsed during ITER is ignored and produces no extra valid.
5. N=8 UDIV a=200, b=7 -> result=28. Then UREM a=200, b=7 -> result=4. Each pulses valid once; ready is 0 in the DONE cycle and 1 in the next cycle.
6. N=8 divide by zero: UDIV a=9, b=0 -> result=8'hFF, divzero=1. UREM a=9, b=0 -> result=9, divzero=1, L=9. Result holds across 20 idle cycles with changing a/b.
